// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem_arbiter_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [7:0] cpu_adr;
    logic [7:0] cpu_wdata;
    logic       dma_req;
    logic       dma_we;
    logic [7:0] dma_adr;
    logic [7:0] dma_wdata;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic       cpu_done;
    logic       dma_done;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] mem_adr;
    logic [7:0] mem_wdata;
    logic       mem_read;
    logic       mem_write;
    logic       mem_ready;
    logic [7:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  dma_req, dma_we, dma_adr, dma_wdata,
        input  mem_ready, mem_rdata,
        output cpu_gnt, dma_gnt, cpu_done, dma_done, err, rdata,
        output mem_adr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output dma_req, dma_we, dma_adr, dma_wdata,
        output mem_ready, mem_rdata,
        input  cpu_gnt, dma_gnt, cpu_done, dma_done, err, rdata,
        input  mem_adr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) memory arbiter: CPU-priority with a starvation cap for DMA,
// single outstanding access with a wait-state timeout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic         ph1,
    input  logic         reset_b,
    mem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic [WW-1:0] wait_q;
    logic          owner_dma_q;
    logic          we_q;
    logic          cpu_gnt_q, dma_gnt_q;
    logic          cpu_done_q, dma_done_q;
    logic          err_q;
    logic [7:0]    rdata_q;
    logic [7:0]    mem_adr_q, mem_wdata_q;
    logic          mem_read_q, mem_write_q;

    logic          dma_wins_d;
    logic          sel_we_d;
    logic [7:0]    sel_adr_d, sel_wdata_d;
    logic [WW-1:0] wait_d;
    logic          finish_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        dma_wins_d  = 1'b0;
        sel_we_d    = bus.cpu_we;
        sel_adr_d   = bus.cpu_adr;
        sel_wdata_d = bus.cpu_wdata;
        if (bus.dma_req && (!bus.cpu_req || starve_q == SW'(STARVE_LIMIT))) begin
            dma_wins_d  = 1'b1;
            sel_we_d    = bus.dma_we;
            sel_adr_d   = bus.dma_adr;
            sel_wdata_d = bus.dma_wdata;
        end
        wait_d   = wait_q + WW'(1);
        // Ready in the last allowed cycle completes normally rather than timing out.
        finish_d = bus.mem_ready || (wait_d == WW'(TIMEOUT));
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            owner_dma_q <= 1'b0;
            we_q        <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        owner_dma_q <= dma_wins_d;
                        we_q        <= sel_we_d;
                        mem_adr_q   <= sel_adr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_read_q  <= !sel_we_d;
                        mem_write_q <= sel_we_d;
                        wait_q      <= '0;
                        state_q     <= ACCESS;
                        if (dma_wins_d) begin
                            dma_gnt_q <= 1'b1;
                            starve_q  <= '0;
                        end else begin
                            cpu_gnt_q <= 1'b1;
                            if (bus.dma_req && starve_q != SW'(STARVE_LIMIT))
                                starve_q <= starve_q + SW'(1);
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.mem_ready)
                        wait_q <= wait_d;
                    if (finish_d) begin
                        err_q       <= !bus.mem_ready;
                        if (bus.mem_ready && !we_q)
                            rdata_q <= bus.mem_rdata;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cpu_done_q  <= !owner_dma_q;
                        dma_done_q  <= owner_dma_q;
                        state_q     <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single accesses, wait states, starvation cap,
// timeout boundary, asynchronous reset mid-access and mem_ready noise in IDLE.
module tb_mem_arbiter;
    logic ph1;
    logic reset_b;
    int   n_vec;
    int   n_err;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .ph1     (ph1),
        .reset_b (reset_b),
        .bus     (bus.slave)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_b       = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_adr   = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_adr   = 8'h00;
        bus.dma_wdata = 8'h00;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'h00;
        #1;
        check("rst_gnt",  {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'd0);
        check("rst_done", {30'd0, bus.cpu_done, bus.dma_done}, 32'd0);
        check("rst_mem",  {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_data", {8'd0, bus.rdata, bus.mem_adr, bus.mem_wdata}, 32'd0);
        check("rst_err",  {31'd0, bus.err}, 32'd0);
        tick();
        tick();
        reset_b = 1'b1;

        // CPU read 0x10, ready on first ACCESS cycle, data 0xA5.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h10;
        bus.mem_rdata = 8'hA5;
        tick();
        check("rd_gnt",   {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'h2);
        check("rd_mem",   {30'd0, bus.mem_read, bus.mem_write}, 32'h2);
        check("rd_adr",   {24'd0, bus.mem_adr}, 32'h10);
        check("rd_nodn",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h0);
        bus.mem_ready = 1'b1;
        tick();
        check("rd_done",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h2);
        check("rd_rdata", {24'd0, bus.rdata}, 32'hA5);
        check("rd_err",   {31'd0, bus.err}, 32'h0);
        check("rd_memof", {30'd0, bus.mem_read, bus.mem_write}, 32'h0);
        bus.cpu_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        check("rd_idle",  {28'd0, bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done}, 32'h0);

        // DMA write 0x3C to 0x20, ready after three wait cycles.
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_adr = 8'h20; bus.dma_wdata = 8'h3C;
        tick();
        check("wr_gnt", {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'h1);
        for (int c = 0; c < 4; c++) begin
            check("wr_mem",   {30'd0, bus.mem_read, bus.mem_write}, 32'h1);
            check("wr_adr",   {16'd0, bus.mem_adr, bus.mem_wdata}, 32'h203C);
            check("wr_nodn",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h0);
            if (c == 3) bus.mem_ready = 1'b1;
            tick();
        end
        check("wr_done",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h1);
        check("wr_rdata", {24'd0, bus.rdata}, 32'hA5);
        check("wr_err",   {31'd0, bus.err}, 32'h0);
        bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // Both requesters held: CPU x4, DMA, CPU x4, DMA.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_adr = 8'h30; bus.cpu_wdata = 8'h11;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_adr = 8'h31; bus.dma_wdata = 8'h22;
        bus.mem_ready = 1'b1;
        for (int g = 0; g < 10; g++) begin
            logic [1:0] exp_g;
            exp_g = (g == 4 || g == 9) ? 2'b01 : 2'b10;
            tick();
            check("st_gnt",  {30'd0, bus.cpu_gnt, bus.dma_gnt}, {30'd0, exp_g});
            tick();
            check("st_done", {30'd0, bus.cpu_done, bus.dma_done}, {30'd0, exp_g});
            if (g == 9) begin
                bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
            end
            tick();
        end
        check("st_rdata", {24'd0, bus.rdata}, 32'hA5);

        // Timeout boundary: ready never (err=1), then ready in the 15th ACCESS cycle (err=0).
        for (int m = 0; m < 2; m++) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h40;
            bus.mem_rdata = 8'h77;
            tick();
            check("to_gnt", {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'h2);
            for (int c = 1; c <= 15; c++) begin
                check("to_mem",  {30'd0, bus.mem_read, bus.mem_write}, 32'h2);
                check("to_nodn", {30'd0, bus.cpu_done, bus.dma_done}, 32'h0);
                if (c == 15 && m == 1) bus.mem_ready = 1'b1;
                tick();
            end
            check("to_done",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h2);
            check("to_err",   {31'd0, bus.err}, (m == 0) ? 32'h1 : 32'h0);
            check("to_rdata", {24'd0, bus.rdata}, (m == 0) ? 32'hA5 : 32'h77);
            bus.cpu_req = 1'b0; bus.mem_ready = 1'b0;
            tick();
        end

        // Asynchronous reset in the middle of an ACCESS.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 8'h50;
        bus.mem_rdata = 8'h5A;
        tick();
        check("ar_acc", {30'd0, bus.mem_read, bus.mem_write}, 32'h2);
        #1;
        reset_b = 1'b0;
        #1;
        check("ar_mem",   {30'd0, bus.mem_read, bus.mem_write}, 32'h0);
        check("ar_gnt",   {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'h0);
        check("ar_rdata", {24'd0, bus.rdata}, 32'h0);
        tick();
        check("ar_nodn",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h0);
        reset_b = 1'b1;
        tick();
        check("ar_regnt", {30'd0, bus.cpu_gnt, bus.dma_gnt}, 32'h2);
        check("ar_readr", {24'd0, bus.mem_adr}, 32'h50);
        bus.mem_ready = 1'b1;
        tick();
        check("ar_done",  {30'd0, bus.cpu_done, bus.dma_done}, 32'h2);
        check("ar_rd",    {24'd0, bus.rdata}, 32'h5A);
        bus.cpu_req = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // mem_ready noise in IDLE with no requests must not move any output.
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = i[0];
            bus.mem_rdata = 8'hE0 + 8'(i);
            tick();
            check("ig_ctl",  {26'd0, bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done,
                              bus.mem_read, bus.mem_write}, 32'h0);
            check("ig_data", {7'd0, bus.err, bus.rdata, bus.mem_adr, 8'h00}, 32'h005A_5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 4, the maximum number of consecutive CPU grants while dma_req is pending.
REQ-002 SHALL provide parameter TIMEOUT, default 15, the maximum ACCESS cycles allowed without mem_ready.
REQ-003 ph1  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_b  in  1  asynchronous, active-low reset.
REQ-005 cpu_req, cpu_we  in  1 each  CPU request, held until cpu_done; write (1) or read (0).
REQ-006 cpu_adr, cpu_wdata  in  8 each  CPU address and write data.
REQ-007 dma_req, dma_we  in  1 each; dma_adr, dma_wdata  in  8 each  DMA request, same semantics as the CPU inputs.
REQ-008 cpu_gnt, dma_gnt  out  1 each  one-cycle grant pulse.
REQ-009 cpu_done, dma_done  out  1 each  one-cycle completion pulse.
REQ-010 err  out  1  valid with a done pulse: 1 = timed out.
REQ-011 rdata  out  8  read data, valid from the done cycle until the next read completes.
REQ-012 mem_adr, mem_wdata  out  8 each; mem_read, mem_write  out  1 each  memory port.
REQ-013 mem_ready  in  1  memory completes the current access in this cycle.

Function
REQ-014 SHALL implement exactly 3 states: IDLE, ACCESS, DONE.
REQ-015 In IDLE with no request, the next state SHALL be IDLE.
REQ-016 In IDLE with any request: SHALL pick a winner, register its adr/we/wdata into mem_adr/mem_wdata/internal we, assert the winner's gnt in the next cycle, and go to ACCESS.
REQ-017 Arbitration: CPU SHALL win a tie unless starve_cnt == STARVE_LIMIT, in which case DMA SHALL win; a sole requester always wins.
REQ-018 starve_cnt update: +1 on a CPU grant while dma_req=1, saturating at STARVE_LIMIT; cleared to 0 on a DMA grant; otherwise unchanged.
REQ-019 In ACCESS, mem_read SHALL equal !we and mem_write SHALL equal we; both SHALL be 0 in all other states.
REQ-020 mem_adr and mem_wdata SHALL be stable for the whole of ACCESS.
REQ-021 In ACCESS with mem_ready=1: SHALL capture the memory read data into rdata for a read, clear err, and go to DONE.
REQ-022 wait_cnt SHALL be cleared on ACCESS entry and SHALL increment each ACCESS cycle without mem_ready.
REQ-023 When wait_cnt reaches TIMEOUT with mem_ready=0: SHALL set err=1, leave rdata unchanged, and go to DONE.
REQ-024 mem_ready in the timeout cycle SHALL take precedence over the timeout.
REQ-025 In DONE: the owner's done SHALL be 1, no arbitration SHALL occur, and the next state SHALL be IDLE.
REQ-026 Requesters drop req in the done cycle; a req still high in IDLE SHALL be treated as a new request.
REQ-027 Minimum latency: req high at edge N gives gnt and ACCESS in cycle N+1; with mem_ready=1 in that cycle, done is in cycle N+2, and IDLE is available again at N+3.
REQ-028 Requests arriving during ACCESS or DONE SHALL wait; no request SHALL be lost while req is held.
REQ-029 mem_ready outside ACCESS SHALL be ignored.
REQ-030 At most one gnt and at most one done SHALL be high in any cycle.

Reset
REQ-031 reset_b=0 SHALL immediately force: state IDLE, starve_cnt=0, wait_cnt=0, rdata=0, err=0, mem_adr=0, mem_wdata=0, all gnt/done/mem_read/mem_write=0.
REQ-032 Reset during ACCESS SHALL abort the access; no done SHALL be issued for it.
REQ-033 The first edge after reset_b rises SHALL perform IDLE arbitration normally.

Verification
REQ-034 CPU read adr=0x10, mem_ready=1 on the first ACCESS cycle, memory data 0xA5 -> cpu_gnt at cycle 1, mem_read=1 at cycle 1, cpu_done at cycle 2, rdata=0xA5, err=0.
REQ-035 DMA write adr=0x20, wdata=0x3C, mem_ready after 3 wait cycles -> mem_write=1 and mem_adr=0x20 for 4 cycles, then dma_done, rdata unchanged.
REQ-036 cpu_req and dma_req both held continuously -> grants CPU,CPU,CPU,CPU,DMA,CPU,...; starve_cnt returns to 0 after the DMA grant.
REQ-037 Read with mem_ready held 0 -> done with err=1 after exactly TIMEOUT=15 ACCESS cycles; mem_ready=1 in cycle 15 -> err=0.
REQ-038 reset_b=0 mid-ACCESS -> mem_read/mem_write drop without waiting for an edge, no done is issued, and a fresh grant follows reset release.
REQ-039 Toggle mem_ready in IDLE/DONE with no requests -> no outputs change.
